instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Instruction-memory responder for the fetch stage: serves the word addressed by the program counter, one registered read per cycle.
- Also contains the write side: a byte-stream program loader, fed by the debug/UART unit, which packs bytes into words and fills the memory sequentially until a halt word.
- Sits between the PC register and the IF/ID pipeline register.

Parameters:
- NBITS, 32, instruction/address width.
- NWORDS, 256, memory depth in words (power of two).
- ADDR_W, $clog2(NWORDS), word-index width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- i_PC  input  NBITS  fetch byte address from PC register (changes on negedge).
- o_Instruction  output  NBITS  fetched instruction, registered.
- i_Load_Start  input  1  pulse: begin/restart program load.
- i_Load_Valid  input  1  i_Load_Byte valid.
- i_Load_Byte  input  8  program byte, big-endian within word.
- o_Load_Ready  output  1  loader accepts a byte this cycle.
- o_Load_Done  output  1  load finished (level, held until next start).
- o_Load_Err  output  1  memory filled without halt word.
- o_Load_Count  output  ADDR_W+1  words written in current/last load.

Behaviour:
- Reset (reset==0 at posedge): FSM=IDLE, all outputs 0, write pointer=0, byte index=0. Memory array contents are not cleared. Reset mid-load abandons the load and discards any partial word.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: o_Load_Ready=0. i_Load_Start -> LOAD.
  - LOAD: o_Load_Ready=1. Byte accepted when i_Load_Valid & o_Load_Ready. Byte k of a word (k=0..3) lands in bits [31-8k -: 8].
  - Word write: on the 4th accepted byte, the assembled word is written to mem[ptr] on the same posedge. ptr and o_Load_Count increment by 1.
  - Halt: if the written word == HALT_WORD (0xFFFFFFFF), it is written and counted, then LOAD->DONE. Next cycle: o_Load_Done=1, o_Load_Ready=0.
  - Overflow: if the write fills index NWORDS-1 with a non-halt word -> DONE with o_Load_Err=1. Bytes offered in DONE are not accepted.
  - DONE: i_Load_Start -> LOAD.
- Any start: i_Load_Start in any non-reset state clears ptr, byte index, o_Load_Count, o_Load_Done and o_Load_Err, then enters LOAD. A start in LOAD restarts and discards the partial word. A start coincident with a valid byte: start wins and the byte is dropped.
- Fetch side:
  - Word index = i_PC[ADDR_W+1:2]; i_PC[1:0] ignored.
  - If i_PC >= 4*NWORDS, returns NOP_WORD (0).
  - o_Instruction is registered on posedge: 1-cycle latency from a stable i_PC. PC updates on negedge, so the instruction is valid before the next negedge.
  - While FSM==LOAD, o_Instruction is forced to NOP_WORD, which stalls the pipeline harmlessly.
- Same-address read/write in one cycle cannot be observed, because reads are forced to NOP during LOAD.

Optional Feature:
- Macro: INSTR_MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output o_Misaligned (1 bit), registered alongside o_Instruction, =1 when i_PC[1:0]!=0. Reset value 0; forced to 0 during LOAD.
  - o_Instruction is NOP_WORD whenever o_Misaligned=1.
- Undefined: port absent; low PC bits silently ignored.

Decomposition:
- Shared package mips_pkg:
  - loader state enum {IDLE, LOAD, DONE}.
  - HALT_WORD=32'hFFFFFFFF, NOP_WORD=32'h0, BYTES_PER_WORD=4.
- One natural sub-module: byte_word_packer. It holds the byte index and shift register, and emits a word_valid pulse with the assembled word; it is cleared on start or reset.
- The memory array and FSM stay in instr_mem_loader.

Test Plan:
- Reset: hold reset=0 for 2 cycles with i_PC=0 -> o_Instruction=0, o_Load_Ready=0, o_Load_Done=0, o_Load_Err=0, o_Load_Count=0.
- Basic load and fetch:
  - Start, then bytes 20 08 00 05, 20 09 00 07, FF FF FF FF -> o_Load_Count=3, o_Load_Done=1.
  - Then i_PC=0 -> 0x20080005; i_PC=4 -> 0x20090007; i_PC=8 -> 0xFFFFFFFF; i_PC=0x400 -> 0.
- Back-pressure and gaps: valid toggled every other cycle during load -> same memory image as with continuous bytes. o_Instruction=0 throughout LOAD.
- Restart mid-load:
  - Start, bytes 11 22 (partial), start, then AA BB CC DD FF FF FF FF -> mem[0]=0xAABBCCDD, count=2.
  - Reset asserted mid-word -> IDLE; a following load begins at word 0.
- Overflow: NWORDS=4, stream 5 non-halt words -> 4 words written, o_Load_Err=1, o_Load_Done=1, 5th word's bytes not accepted (o_Load_Ready=0).
- Misalign (macro defined): i_PC=0x6 after load -> o_Misaligned=1, o_Instruction=0. i_PC=0x4 -> o_Misaligned=0 with the correct word.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// mips_pkg: types and constants shared by the instruction memory,
// its program loader and the byte-to-word packer.
//   load_state_t   : loader FSM states (IDLE, LOAD, DONE)
//   HALT_WORD      : word value that terminates a program load
//   NOP_WORD       : word returned whenever a fetch cannot be served
//   BYTES_PER_WORD : number of loader bytes assembled into one word
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte-stream program load channel between the
// debug/UART unit (master) and the instruction memory loader (slave).
//   i_Load_Start : pulse, begin/restart a program load
//   i_Load_Valid : i_Load_Byte carries a byte
//   i_Load_Byte  : program byte, big-endian within a word
//   o_Load_Ready : loader accepts a byte this cycle
//   o_Load_Done  : load finished (level until next start)
//   o_Load_Err   : memory filled without a halt word
//   o_Load_Count : words written by the current/last load
// Parameter ADDR_W must equal the loader's word-index width.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 8
);

  logic              i_Load_Start;
  logic              i_Load_Valid;
  logic [7:0]        i_Load_Byte;
  logic              o_Load_Ready;
  logic              o_Load_Done;
  logic              o_Load_Err;
  logic [ADDR_W:0]   o_Load_Count;

  modport master (
    output i_Load_Start, i_Load_Valid, i_Load_Byte,
    input  o_Load_Ready, o_Load_Done, o_Load_Err, o_Load_Count
  );

  modport slave (
    input  i_Load_Start, i_Load_Valid, i_Load_Byte,
    output o_Load_Ready, o_Load_Done, o_Load_Err, o_Load_Count
  );

endinterface

// File: rtl/instr_mem_loader_byte_word_packer.sv
// byte_word_packer: assembles accepted bytes into big-endian words.
// Byte k of a word lands in bits [NBITS-1-8k -: 8]. On the last byte of
// a word, word_valid pulses combinationally with the complete word so
// the memory write can happen on the same clock edge.
//   clk        : system clock
//   reset      : synchronous, active-low
//   clear      : drop any partial word and restart at byte 0
//   byte_valid : byte_in is accepted this cycle
//   byte_in    : incoming byte
//   word_valid : byte_in completes a word this cycle
//   word       : assembled word (valid when word_valid)
module byte_word_packer
  import mips_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_valid,
  input  logic [7:0]       byte_in,
  output logic             word_valid,
  output logic [NBITS-1:0] word
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx_reg;
  // Holds the first BYTES_PER_WORD-1 bytes; the final byte is taken
  // straight from byte_in so the word is ready on the completing cycle.
  logic [NBITS-9:0] shift_reg;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      idx_reg   <= '0;
      shift_reg <= '0;
    end else if (byte_valid) begin
      shift_reg <= {shift_reg[NBITS-17:0], byte_in};
      idx_reg   <= idx_reg + 1'b1;  // wraps to 0 after the last byte
    end
  end

  assign word_valid = byte_valid && (idx_reg == LAST_IDX);
  assign word       = {shift_reg, byte_in};

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: instruction memory for the fetch stage plus a
// byte-stream program loader that fills it sequentially until a halt
// word (or until the memory is full, which flags an error).
//   clk           : system clock, all state on posedge
//   reset         : synchronous, active-low
//   i_PC          : fetch byte address (word index = i_PC[ADDR_W+1:2])
//   o_Instruction : registered fetched word; NOP while loading or when
//                   i_PC is beyond the memory
//   ld            : program load channel (instr_mem_loader_if.slave)
//   o_Misaligned  : only when INSTR_MEM_MISALIGN_TRAP_EN is defined;
//                   registered flag for i_PC[1:0] != 0 (fetch returns NOP)
// Optional feature macro: INSTR_MEM_MISALIGN_TRAP_EN.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int NWORDS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] i_PC,
  output logic [NBITS-1:0] o_Instruction,
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
  output logic             o_Misaligned,
`endif
  instr_mem_loader_if.slave ld
);

  localparam int ADDR_W = $clog2(NWORDS);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NWORDS - 1);
  // One bit wider than i_PC so 4*NWORDS is representable for any NBITS.
  localparam logic [NBITS:0] PC_LIMIT = (NBITS + 1)'(4 * NWORDS);

  load_state_t state_reg, state_next;

  logic [NBITS-1:0] mem [NWORDS];

  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              done_reg;
  logic              err_reg;
  logic [NBITS-1:0]  instr_reg;

  logic              accept;
  logic              word_valid;
  logic [NBITS-1:0]  word;
  logic              is_halt;
  logic              last_slot;

  // A start in the same cycle as a valid byte wins; the byte is dropped.
  assign accept    = ld.i_Load_Valid && (state_reg == LOAD) && !ld.i_Load_Start;
  assign is_halt   = (word == NBITS'(HALT_WORD));
  assign last_slot = (ptr_reg == LAST_PTR);

  byte_word_packer #(.NBITS(NBITS)) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (ld.i_Load_Start),
    .byte_valid (accept),
    .byte_in    (ld.i_Load_Byte),
    .word_valid (word_valid),
    .word       (word)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    if (ld.i_Load_Start) begin
      state_next = LOAD;
    end else if (state_reg == LOAD && word_valid && (is_halt || last_slot)) begin
      state_next = DONE;
    end
  end

  // Write pointer and load status
  always_ff @(posedge clk) begin
    if (!reset || ld.i_Load_Start) begin
      ptr_reg   <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (word_valid) begin
      ptr_reg   <= ptr_reg + 1'b1;
      count_reg <= count_reg + 1'b1;
      if (is_halt) begin
        done_reg <= 1'b1;
      end else if (last_slot) begin
        done_reg <= 1'b1;
        err_reg  <= 1'b1;
      end
    end
  end

  // Memory write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (word_valid) mem[ptr_reg] <= word;
  end

  // Registered fetch. Forcing NOP during LOAD also hides any same-address
  // read/write collision with the loader.
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
  logic misaligned_reg;

  always_ff @(posedge clk) begin
    if (!reset || state_reg == LOAD) begin
      instr_reg      <= NBITS'(NOP_WORD);
      misaligned_reg <= 1'b0;
    end else begin
      misaligned_reg <= (i_PC[1:0] != 2'b00);
      if (i_PC[1:0] != 2'b00 || {1'b0, i_PC} >= PC_LIMIT)
        instr_reg <= NBITS'(NOP_WORD);
      else
        instr_reg <= mem[i_PC[ADDR_W+1:2]];
    end
  end

  assign o_Misaligned = misaligned_reg;
`else
  always_ff @(posedge clk) begin
    if (!reset || state_reg == LOAD || {1'b0, i_PC} >= PC_LIMIT)
      instr_reg <= NBITS'(NOP_WORD);
    else
      instr_reg <= mem[i_PC[ADDR_W+1:2]];
  end
`endif

  assign o_Instruction   = instr_reg;
  assign ld.o_Load_Ready = (state_reg == LOAD);
  assign ld.o_Load_Done  = done_reg;
  assign ld.o_Load_Err   = err_reg;
  assign ld.o_Load_Count = count_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader, built with a 4-word memory so the
// overflow path is reachable. Inputs change 1 time unit after posedge;
// outputs are sampled at the same point.
module tb_instr_mem_loader;

  localparam int NBITS  = 32;
  localparam int NWORDS = 4;
  localparam int ADDR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NBITS-1:0] pc;
  logic [NBITS-1:0] instr;
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
  logic             misaligned;
`endif

  int tests = 0;
  int fails = 0;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) ld_if ();

  instr_mem_loader #(.NBITS(NBITS), .NWORDS(NWORDS)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_PC          (pc),
    .o_Instruction (instr),
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
    .o_Misaligned  (misaligned),
`endif
    .ld            (ld_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ld_if.i_Load_Start = 1'b1;
    tick();
    ld_if.i_Load_Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_if.i_Load_Valid = 1'b1;
    ld_if.i_Load_Byte  = b;
    tick();
    ld_if.i_Load_Valid = 1'b0;
    ld_if.i_Load_Byte  = 8'hEE;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pc    = '0;
    tick();
    tick();
    tests++;
    if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 00000000", instr); end
    tests++;
    if (ld_if.o_Load_Ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", ld_if.o_Load_Ready); end
    tests++;
    if (ld_if.o_Load_Done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", ld_if.o_Load_Done); end
    tests++;
    if (ld_if.o_Load_Err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", ld_if.o_Load_Err); end
    tests++;
    if (ld_if.o_Load_Count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", ld_if.o_Load_Count); end
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
    tests++;
    if (misaligned !== 1'b0) begin fails++; $display("FAIL reset_misaligned got %b exp 0", misaligned); end
`endif
    reset = 1'b1;
    tick();
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_basic_load();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h2008_0005;
    exp_w[1] = 32'h2009_0007;
    exp_w[2] = 32'hFFFF_FFFF;
    pulse_start();
    tests++;
    if (ld_if.o_Load_Ready !== 1'b1) begin fails++; $display("FAIL basic_ready got %b exp 1", ld_if.o_Load_Ready); end
    for (int i = 0; i < 3; i++) send_word(exp_w[i]);
    tests++;
    if (ld_if.o_Load_Count !== 3'd3) begin fails++; $display("FAIL basic_count got %0d exp 3", ld_if.o_Load_Count); end
    tests++;
    if (ld_if.o_Load_Done !== 1'b1) begin fails++; $display("FAIL basic_done got %b exp 1", ld_if.o_Load_Done); end
    tests++;
    if (ld_if.o_Load_Ready !== 1'b0) begin fails++; $display("FAIL basic_ready_after got %b exp 0", ld_if.o_Load_Ready); end
    tests++;
    if (ld_if.o_Load_Err !== 1'b0) begin fails++; $display("FAIL basic_err got %b exp 0", ld_if.o_Load_Err); end
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 * i);
      tick();
      tests++;
      if (instr !== exp_w[i]) begin fails++; $display("FAIL basic_fetch pc=%h got %h exp %h", pc, instr, exp_w[i]); end
    end
    pc = 32'h400;
    tick();
    tests++;
    if (instr !== 32'h0) begin fails++; $display("FAIL basic_fetch_oob400 got %h exp 00000000", instr); end
    pc = 32'h10;  // first byte address past a 4-word memory
    tick();
    tests++;
    if (instr !== 32'h0) begin fails++; $display("FAIL basic_fetch_oob10 got %h exp 00000000", instr); end
    $display("[TB] basic load: 3 words loaded and fetched");
  endtask

  task automatic test_gaps();
    logic [31:0] exp_w [3];
    logic [31:0] w;
    exp_w[0] = 32'h0102_0304;
    exp_w[1] = 32'hA55A_C33C;
    exp_w[2] = 32'hFFFF_FFFF;
    pc = 32'h4;  // leave a non-zero word on o_Instruction before loading
    tick();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      w = exp_w[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[31 - 8*k -: 8]);
        if (!(i == 2 && k == 3)) begin
          tests++;
          if (instr !== 32'h0) begin fails++; $display("FAIL gaps_nop_during_load got %h exp 00000000", instr); end
          tick();  // idle cycle with garbage on the byte lane
        end
      end
    end
    tests++;
    if (ld_if.o_Load_Count !== 3'd3 || ld_if.o_Load_Done !== 1'b1) begin
      fails++; $display("FAIL gaps_status count=%0d done=%b exp count=3 done=1", ld_if.o_Load_Count, ld_if.o_Load_Done);
    end
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 * i);
      tick();
      tests++;
      if (instr !== exp_w[i]) begin fails++; $display("FAIL gaps_fetch pc=%h got %h exp %h", pc, instr, exp_w[i]); end
    end
    $display("[TB] gaps: sparse byte stream loaded");
  endtask

  task automatic test_restart();
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    // Restart with a valid byte on the same cycle; the byte must be dropped.
    ld_if.i_Load_Start = 1'b1;
    ld_if.i_Load_Valid = 1'b1;
    ld_if.i_Load_Byte  = 8'h33;
    tick();
    ld_if.i_Load_Start = 1'b0;
    ld_if.i_Load_Valid = 1'b0;
    tests++;
    if (ld_if.o_Load_Count !== 3'd0 || ld_if.o_Load_Done !== 1'b0) begin
      fails++; $display("FAIL restart_cleared count=%0d done=%b exp 0 0", ld_if.o_Load_Count, ld_if.o_Load_Done);
    end
    send_word(32'hAABB_CCDD);
    send_word(32'hFFFF_FFFF);
    tests++;
    if (ld_if.o_Load_Count !== 3'd2) begin fails++; $display("FAIL restart_count got %0d exp 2", ld_if.o_Load_Count); end
    pc = 32'h0;
    tick();
    tests++;
    if (instr !== 32'hAABB_CCDD) begin fails++; $display("FAIL restart_mem0 got %h exp aabbccdd", instr); end
    pc = 32'h4;
    tick();
    tests++;
    if (instr !== 32'hFFFF_FFFF) begin fails++; $display("FAIL restart_mem1 got %h exp ffffffff", instr); end
    $display("[TB] restart: partial word discarded");
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b0;
    tick();
    tests++;
    if (ld_if.o_Load_Ready !== 1'b0 || ld_if.o_Load_Count !== 3'd0) begin
      fails++; $display("FAIL midreset_idle ready=%b count=%0d exp 0 0", ld_if.o_Load_Ready, ld_if.o_Load_Count);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (ld_if.o_Load_Ready !== 1'b0) begin fails++; $display("FAIL midreset_stays_idle ready=%b exp 0", ld_if.o_Load_Ready); end
    pulse_start();
    send_word(32'h1020_3040);
    send_word(32'hFFFF_FFFF);
    tests++;
    if (ld_if.o_Load_Count !== 3'd2 || ld_if.o_Load_Done !== 1'b1) begin
      fails++; $display("FAIL midreset_status count=%0d done=%b exp 2 1", ld_if.o_Load_Count, ld_if.o_Load_Done);
    end
    pc = 32'h0;
    tick();
    tests++;
    if (instr !== 32'h1020_3040) begin fails++; $display("FAIL midreset_mem0 got %h exp 10203040", instr); end
    $display("[TB] reset mid-load: reload starts at word 0");
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h1111_1111;
    exp_w[1] = 32'h2222_2222;
    exp_w[2] = 32'h3333_3333;
    exp_w[3] = 32'h4444_4444;
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(exp_w[i]);
    tests++;
    if (ld_if.o_Load_Err !== 1'b1 || ld_if.o_Load_Done !== 1'b1) begin
      fails++; $display("FAIL overflow_flags err=%b done=%b exp 1 1", ld_if.o_Load_Err, ld_if.o_Load_Done);
    end
    tests++;
    if (ld_if.o_Load_Count !== 3'd4) begin fails++; $display("FAIL overflow_count got %0d exp 4", ld_if.o_Load_Count); end
    // Fifth word: bytes are offered but must not be taken.
    ld_if.i_Load_Valid = 1'b1;
    ld_if.i_Load_Byte  = 8'h55;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (ld_if.o_Load_Ready !== 1'b0) begin fails++; $display("FAIL overflow_ready got %b exp 0", ld_if.o_Load_Ready); end
      tick();
    end
    ld_if.i_Load_Valid = 1'b0;
    tests++;
    if (ld_if.o_Load_Count !== 3'd4) begin fails++; $display("FAIL overflow_count_after got %0d exp 4", ld_if.o_Load_Count); end
    for (int i = 0; i < 4; i++) begin
      pc = 32'(4 * i);
      tick();
      tests++;
      if (instr !== exp_w[i]) begin fails++; $display("FAIL overflow_fetch pc=%h got %h exp %h", pc, instr, exp_w[i]); end
    end
    $display("[TB] overflow: 4 words written, error flagged");
  endtask

  // Runs after the overflow image (word 1 = 0x22222222).
  task automatic test_low_pc_bits();
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
    pc = 32'h6;
    tick();
    tests++;
    if (misaligned !== 1'b1 || instr !== 32'h0) begin
      fails++; $display("FAIL misalign_trap mis=%b instr=%h exp 1 00000000", misaligned, instr);
    end
    pc = 32'h4;
    tick();
    tests++;
    if (misaligned !== 1'b0 || instr !== 32'h2222_2222) begin
      fails++; $display("FAIL misalign_clear mis=%b instr=%h exp 0 22222222", misaligned, instr);
    end
    $display("[TB] misalign: trap flag checked");
`else
    pc = 32'h6;
    tick();
    tests++;
    if (instr !== 32'h2222_2222) begin fails++; $display("FAIL low_bits_ignored got %h exp 22222222", instr); end
    $display("[TB] low pc bits: ignored");
`endif
  endtask

  initial begin
    reset              = 1'b0;
    pc                 = '0;
    ld_if.i_Load_Start = 1'b0;
    ld_if.i_Load_Valid = 1'b0;
    ld_if.i_Load_Byte  = 8'h00;
    test_reset();
    test_basic_load();
    test_gaps();
    test_restart();
    test_reset_mid_load();
    test_overflow();
    test_low_pc_bits();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
